// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined MIPS core.
// Runs a req/ready handshake to instruction memory and absorbs decode-stage redirects.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Stall_F,
  input  logic             Stall_D,
  input  logic             PCSrc_D,
  input  logic [WIDTH-1:0] PCBranch_D,
  input  logic             Jump_D,
  input  logic [WIDTH-1:0] PCJump_D,
  input  logic [31:0]      IMemRdata,
  input  logic             IMemReady,
  output logic             IMemReq,
  output logic [WIDTH-1:0] IMemAddr,
  output logic             IMemStall,
  output logic [31:0]      Instr_D,
  output logic [WIDTH-1:0] PCPlus4_D,
  output logic             Valid_D
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc4_q, skid_pc4_d;
  logic             skid_valid_q, skid_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;

  logic             redir_s;
  logic [WIDTH-1:0] target_s;
  logic             done_s;
  logic             hold_fetch_s;
  logic [WIDTH-1:0] pc_plus4_s;

  // Next-state and next-register computation for the whole stage.
  always_comb begin
    redir_s      = !Stall_D && (Jump_D || PCSrc_D);
    target_s     = Jump_D ? PCJump_D : PCBranch_D;
    done_s       = req_q && IMemReady;
    // Decode stalled alone cannot accept a word, so fetch behaves as stalled too.
    hold_fetch_s = Stall_F || Stall_D;
    pc_plus4_s   = pc_q + PC_STEP;

    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    case (state_q)
      FETCH: begin
        if (done_s) begin
          if (redir_s) begin
            pc_d    = target_s;
            instr_d = 32'h0000_0000;
            pc4_d   = {WIDTH{1'b0}};
            valid_d = 1'b0;
          end else if (!hold_fetch_s) begin
            instr_d = IMemRdata;
            pc4_d   = pc_plus4_s;
            valid_d = 1'b1;
            pc_d    = pc_plus4_s;
          end else begin
            skid_instr_d = IMemRdata;
            skid_pc4_d   = pc_plus4_s;
            skid_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else begin
          if (redir_s) begin
            pend_d  = target_s;
            instr_d = 32'h0000_0000;
            pc4_d   = {WIDTH{1'b0}};
            valid_d = 1'b0;
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (redir_s) begin
          pend_d  = target_s;
          instr_d = 32'h0000_0000;
          pc4_d   = {WIDTH{1'b0}};
          valid_d = 1'b0;
        end else begin
          pend_d = pend_q;
        end
        if (done_s) begin
          pc_d    = redir_s ? target_s : pend_q;
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redir_s) begin
          skid_valid_d = 1'b0;
          pc_d         = target_s;
          instr_d      = 32'h0000_0000;
          pc4_d        = {WIDTH{1'b0}};
          valid_d      = 1'b0;
          state_d      = FETCH;
        end else if (!Stall_F && !Stall_D && skid_valid_q) begin
          instr_d      = skid_instr_q;
          pc4_d        = skid_pc4_q;
          valid_d      = 1'b1;
          skid_valid_d = 1'b0;
          pc_d         = pc_plus4_s;
          state_d      = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    req_d = (state_d != HOLD);
  end

  // State, PC, skid buffer and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pend_q       <= {WIDTH{1'b0}};
      skid_instr_q <= 32'h0000_0000;
      skid_pc4_q   <= {WIDTH{1'b0}};
      skid_valid_q <= 1'b0;
      instr_q      <= 32'h0000_0000;
      pc4_q        <= {WIDTH{1'b0}};
      valid_q      <= 1'b0;
      req_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
    end
  end

  assign IMemReq   = req_q;
  assign IMemAddr  = pc_q;
  assign IMemStall = ((state_q == FETCH) && !IMemReady) || (state_q == DRAIN);
  assign Instr_D   = instr_q;
  assign PCPlus4_D = pc4_q;
  assign Valid_D   = valid_q;

endmodule
